// File: rtl/pong_pkg.sv
// Shared pong definitions: paddle FSM encoding, screen geometry defaults and
// the miss-LFSR constants used by the AI paddle.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_UP   = 2'd2,
    ST_DOWN = 2'd3
  } paddle_state_e;

  localparam int SCREEN_H_DEF = 480;
  localparam int PADDLE_H_DEF = 80;

  // x^8+x^6+x^5+x^4+1, Fibonacci form shifting left; taps are state bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for a slow tick already registered in the clock_in domain.
// The history register resets to 1 so a tick that is high at reset release is not an edge.
module tick_edge_detect (
  input  logic clock_in,
  input  logic reset,
  input  logic tick,
  output logic rise
);

  logic tick_q;

  always_ff @(posedge clock_in) begin
    if (reset) tick_q <= 1'b1;
    else       tick_q <= tick;
  end

  assign rise = tick & ~tick_q;

endmodule

// File: rtl/ai_paddle_tracker.sv
// AI paddle: one STEP per step_clk rising edge, steering toward the ball when it
// approaches and toward screen centre otherwise. Define AI_MISS_EN for LFSR-driven missed steps.
module ai_paddle_tracker
  import pong_pkg::*;
#(
  parameter int Y_W          = 10,
  parameter int SCREEN_H     = SCREEN_H_DEF,
  parameter int PADDLE_H     = PADDLE_H_DEF,
  parameter int STEP         = 2,
  parameter int DEADBAND     = 4,
  parameter int PADDLE_Y_RST = 200
) (
  input  logic           clock_in,
  input  logic           reset,
  input  logic           step_clk,
  input  logic           enable,
  input  logic [Y_W-1:0] ball_y,
  input  logic           ball_toward,
  output logic [Y_W-1:0] paddle_y,
  output logic           step_pulse,
  output logic           moving_up,
  output logic           moving_down
);

  localparam int EW = Y_W + 2;
  localparam logic [Y_W-1:0] Y_MAX  = Y_W'(SCREEN_H - PADDLE_H);
  localparam logic [Y_W-1:0] Y_BOT  = Y_W'(SCREEN_H - 1);
  localparam logic [Y_W-1:0] Y_MID  = Y_W'(SCREEN_H / 2);
  localparam logic [Y_W-1:0] STEP_Y = Y_W'(STEP);
  localparam logic [Y_W-1:0] DN_LIM = Y_W'(SCREEN_H - PADDLE_H - STEP);
  localparam logic [EW-1:0]  HALF_H = EW'(PADDLE_H / 2);
  localparam logic signed [EW-1:0] DB = EW'(DEADBAND);

  paddle_state_e state, nxt;
  logic                 rise, miss, take, up_ok, dn_ok;
  logic [Y_W-1:0]       target, up_y, dn_y;
  logic [EW-1:0]        centre;
  logic signed [EW-1:0] err;

  tick_edge_detect u_tick (
    .clock_in (clock_in),
    .reset    (reset),
    .tick     (step_clk),
    .rise     (rise)
  );

`ifdef AI_MISS_EN
  logic [7:0] lfsr;

  always_ff @(posedge clock_in) begin
    if (reset)     lfsr <= LFSR_SEED;
    else if (rise) lfsr <= lfsr_next(lfsr);
  end

  assign miss = (lfsr[2:0] == 3'b000);
`else
  assign miss = 1'b0;
`endif

  assign target = ball_toward ? ((ball_y > Y_BOT) ? Y_BOT : ball_y) : Y_MID;
  assign centre = {2'b00, paddle_y} + HALF_H;
  assign err    = $signed({2'b00, target}) - $signed(centre);

  always_comb begin
    nxt = ST_HOLD;
    if (!enable)       nxt = ST_IDLE;
    else if (err > DB)  nxt = ST_DOWN;
    else if (err < -DB) nxt = ST_UP;
  end

  // Step decision uses the registered state; a bound already reached means no move and no pulse.
  assign up_ok = (state == ST_UP)   && (paddle_y != '0);
  assign dn_ok = (state == ST_DOWN) && (paddle_y < Y_MAX);
  assign up_y  = (paddle_y < STEP_Y) ? '0 : paddle_y - STEP_Y;
  assign dn_y  = (paddle_y > DN_LIM) ? Y_MAX : paddle_y + STEP_Y;
  assign take  = rise & enable & (up_ok | dn_ok) & ~miss;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state       <= ST_IDLE;
      paddle_y    <= Y_W'(PADDLE_Y_RST);
      step_pulse  <= 1'b0;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
    end else begin
      state       <= nxt;
      moving_up   <= (nxt == ST_UP);
      moving_down <= (nxt == ST_DOWN);
      step_pulse  <= take;
      if (take) paddle_y <= up_ok ? up_y : dn_y;
    end
  end

endmodule

// File: tb/tb_ai_paddle_tracker.sv
// Directed + randomized bench for ai_paddle_tracker against a per-step arithmetic model.
module tb_ai_paddle_tracker;

  logic       clock_in = 1'b0;
  logic       reset = 1'b1;
  logic       step_clk = 1'b1;
  logic       enable = 1'b1;
  logic       ball_toward = 1'b1;
  logic [9:0] ball_y = 10'd400;
  logic [9:0] paddle_y;
  logic       step_pulse, moving_up, moving_down;

  int cmps = 0, fails = 0, pulses = 0;
  int m_pad = 200, m_moves = 0, m_lfsr = 8'hA5;
  int p0, mv0;

  ai_paddle_tracker dut (
    .clock_in    (clock_in),
    .reset       (reset),
    .step_clk    (step_clk),
    .enable      (enable),
    .ball_y      (ball_y),
    .ball_toward (ball_toward),
    .paddle_y    (paddle_y),
    .step_pulse  (step_pulse),
    .moving_up   (moving_up),
    .moving_down (moving_down)
  );

  always #5 clock_in = ~clock_in;

  // Counts strobes seen on the previous cycle; read only at negedges by the stimulus.
  always @(posedge clock_in) if (step_pulse === 1'b1) pulses++;

  task automatic chk(input string tag, input int obs, input int exp);
    cmps++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int err_of(input int pad);
    int t;
    if (ball_toward) t = (int'(ball_y) > 479) ? 479 : int'(ball_y);
    else             t = 240;
    return t - (pad + 40);
  endfunction

  // One step_clk period: rise, check the step one cycle later, check the strobe is single-cycle.
  task automatic do_rise(input string tag, input bit drop_en);
    int  e, np;
    bit  mv, miss;
    @(negedge clock_in);
    step_clk = 1'b1;
    if (drop_en) enable = 1'b0;
    e    = err_of(m_pad);
    miss = 1'b0;
`ifdef AI_MISS_EN
    miss   = ((m_lfsr % 8) == 0);
    m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1)) & 255;
`endif
    np = m_pad;
    mv = 1'b0;
    if (enable && !miss) begin
      if (e > 4 && m_pad < 400)    begin np = (m_pad + 2 > 400) ? 400 : m_pad + 2; mv = 1'b1; end
      else if (e < -4 && m_pad > 0) begin np = (m_pad < 2) ? 0 : m_pad - 2;         mv = 1'b1; end
    end
    @(negedge clock_in);
    chk({tag, ".paddle_y"}, int'(paddle_y), np);
    chk({tag, ".step_pulse"}, int'(step_pulse), int'(mv));
    if (!enable) begin
      chk({tag, ".idle_up"}, int'(moving_up), 0);
      chk({tag, ".idle_down"}, int'(moving_down), 0);
    end
    m_pad   = np;
    m_moves += int'(mv);
    @(negedge clock_in);
    chk({tag, ".pulse_width"}, int'(step_pulse), 0);
    step_clk = 1'b0;
    repeat (2) @(negedge clock_in);
    e = err_of(m_pad);
    chk({tag, ".moving_down"}, int'(moving_down), int'(enable && e > 4));
    chk({tag, ".moving_up"}, int'(moving_up), int'(enable && e < -4));
  endtask

  initial begin
    // Reset with step_clk high: no false edge at release.
    repeat (3) @(negedge clock_in);
    chk("rst.paddle_y", int'(paddle_y), 200);
    chk("rst.step_pulse", int'(step_pulse), 0);
    chk("rst.moving_up", int'(moving_up), 0);
    chk("rst.moving_down", int'(moving_down), 0);
    reset = 1'b0;
    repeat (4) @(negedge clock_in);
    chk("rel.no_false_edge", int'(paddle_y), 200);
    chk("rel.no_pulse", pulses, 0);
    chk("rel.moving_down", int'(moving_down), 1);
    step_clk = 1'b0;

    // Ten steps toward ball_y=400.
    p0 = pulses; mv0 = m_moves;
    for (int i = 0; i < 10; i++) do_rise("down10", 1'b0);
    chk("down10.final", int'(paddle_y), m_pad);
    chk("down10.pulses", pulses - p0, m_moves - mv0);
`ifndef AI_MISS_EN
    chk("down10.abs", int'(paddle_y), 220);
`endif

    // Up to the top bound, then steps at the bound do nothing.
    ball_y = 10'd0;
    for (int i = 0; i < 200 && m_pad > 2; i++) do_rise("climb", 1'b0);
    p0 = pulses; mv0 = m_moves;
    for (int i = 0; i < 3; i++) do_rise("top", 1'b0);
    chk("top.paddle_y", int'(paddle_y), 0);
    chk("top.pulses", pulses - p0, m_moves - mv0);
`ifndef AI_MISS_EN
    chk("top.one_pulse", pulses - p0, 1);
`endif

    // From 100, ball receding: settle at centre and hold without pulses.
    ball_y = 10'd400;
    for (int i = 0; i < 200 && m_pad < 100; i++) do_rise("to100", 1'b0);
    ball_toward = 1'b0;
    for (int i = 0; i < 200 && (err_of(m_pad) > 4 || err_of(m_pad) < -4); i++) do_rise("centre", 1'b0);
    chk("centre.paddle_y", int'(paddle_y), 196);
    p0 = pulses;
    for (int i = 0; i < 3; i++) do_rise("hold", 1'b0);
    chk("hold.no_pulses", pulses - p0, 0);

    // enable drops on the same cycle as a rise.
    ball_toward = 1'b1;
    ball_y = 10'd10;
    @(negedge clock_in);
    do_rise("en_drop", 1'b1);
    enable = 1'b1;

    // Randomized targets, direction and enable.
    for (int i = 0; i < 40; i++) begin
      ball_y      = 10'($urandom_range(0, 1023));
      ball_toward = 1'($urandom_range(0, 1));
      enable      = ($urandom_range(0, 7) != 0);
      for (int k = 0; k < int'($urandom_range(1, 4)); k++)
        do_rise("rand", ($urandom_range(0, 9) == 0));
      enable = 1'b1;
    end

    // Long run toward alternating far targets.
    ball_toward = 1'b1;
    p0 = pulses; mv0 = m_moves;
    for (int i = 0; i < 64; i++) begin
      ball_y = ((i / 16) % 2 != 0) ? 10'd0 : 10'd1000;
      do_rise("far64", 1'b0);
    end
    chk("far64.pulses", pulses - p0, m_moves - mv0);

    // Reset coinciding with a genuine rise: reset wins.
    @(negedge clock_in);
    reset = 1'b1;
    step_clk = 1'b1;
    @(negedge clock_in);
    chk("rst_rise.paddle_y", int'(paddle_y), 200);
    chk("rst_rise.step_pulse", int'(step_pulse), 0);
    reset = 1'b0;
    @(negedge clock_in);
    chk("rst_rise.after", int'(paddle_y), 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
    $finish;
  end

endmodule
